// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV64M multiply/divide unit.
package muldiv_pkg;

  // RV M-extension funct3 encodings
  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    FIX,
    SPECIAL,
    DONE
  } state_t;

  // Result comes from the upper lane: high product half (MULH*) or remainder (REM*)
  function automatic logic f3_upper_lane(input logic [2:0] f3);
    return f3[2] ? f3[1] : (f3[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Two-lane conditional two's-complement negation. With chain=1 the lanes
// form one 2W-bit value {y1,y0}; with chain=0 they are negated independently.
module muldiv_sign_fix #(
  parameter int W = 64
) (
  input  logic [W-1:0] x0,
  input  logic [W-1:0] x1,
  input  logic         neg0,
  input  logic         neg1,
  input  logic         chain,
  output logic [W-1:0] y0,
  output logic [W-1:0] y1
);

  logic carry0;
  logic inc1;

  // Negate each lane; the upper lane's +1 is the lower lane's carry when chained
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    carry0 = neg0 & (x0 == '0);
    inc1   = chain ? carry0 : 1'b1;
    y0     = neg0 ? (~x0 + {{(W-1){1'b0}}, 1'b1}) : x0;
    y1     = neg1 ? (~x1 + {{(W-1){1'b0}}, inc1}) : x1;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit for the EXE stage.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              enable,
  input  logic              start,
  input  logic              kill,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [2:0]          f3_q;
  logic [2*DATA_W-1:0] acc_q;     // product, or {remainder, quotient}
  logic [DATA_W-1:0]   opnd_q;    // multiplicand or divisor magnitude
  logic                neg_q_q;   // sign of product / quotient
  logic                neg_r_q;   // sign of remainder
  logic                div0_q;

  logic                a_signed, b_signed, a_neg, b_neg;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic                b_zero, ovf, special_in, accept;
  logic [DATA_W:0]     mul_sum, div_shift, div_diff;
  logic [2*DATA_W-1:0] div_next;
  logic [DATA_W-1:0]   fix_lo, fix_hi, fix_val, spec_val;

  // Operand signedness, magnitude and special-case detection at issue
  always_comb begin
    a_signed   = (funct3 == MD_MULH) || (funct3 == MD_MULHSU) ||
                 (funct3 == MD_DIV)  || (funct3 == MD_REM);
    b_signed   = (funct3 == MD_MULH) || (funct3 == MD_DIV) || (funct3 == MD_REM);
    a_neg      = a_signed & op_a[DATA_W-1];
    b_neg      = b_signed & op_b[DATA_W-1];
    b_zero     = (op_b == '0);
    ovf        = ((funct3 == MD_DIV) || (funct3 == MD_REM)) &&
                 (op_a == {1'b1, {(DATA_W-1){1'b0}}}) && (op_b == '1);
    special_in = funct3[2] && (b_zero || ovf);
    accept     = (state_q == IDLE) && start && !kill;
  end

  muldiv_sign_fix #(.W(DATA_W)) u_in_fix (
    .x0    (op_a),
    .x1    (op_b),
    .neg0  (a_neg),
    .neg1  (b_neg),
    .chain (1'b0),
    .y0    (a_mag),
    .y1    (b_mag)
  );

  // One shift-add or restoring shift-subtract step
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = acc_q[2*DATA_W-1:DATA_W-1];
    div_diff  = div_shift - {1'b0, opnd_q};
    div_next  = div_diff[DATA_W] ? {div_shift[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0}
                                 : {div_diff[DATA_W-1:0],  acc_q[DATA_W-2:0], 1'b1};
  end

  muldiv_sign_fix #(.W(DATA_W)) u_out_fix (
    .x0    (acc_q[DATA_W-1:0]),
    .x1    (acc_q[2*DATA_W-1:DATA_W]),
    .neg0  (neg_q_q),
    .neg1  (f3_q[2] ? neg_r_q : neg_q_q),
    .chain (~f3_q[2]),
    .y0    (fix_lo),
    .y1    (fix_hi)
  );

  // Final result selection for normal and special paths
  always_comb begin
    fix_val  = f3_upper_lane(f3_q) ? fix_hi : fix_lo;
    if (f3_q[1]) spec_val = div0_q ? acc_q[DATA_W-1:0] : '0;
    else         spec_val = div0_q ? '1 : acc_q[DATA_W-1:0];
  end

  // Next-state logic; kill returns any active state to IDLE
  always_comb begin
    state_d = state_q;
    if (kill && state_q != IDLE) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (accept) state_d = special_in ? SPECIAL : CALC;
        CALC:    if (cnt_q == CNT_W'(1)) state_d = FIX;
        FIX:     state_d = DONE;
        SPECIAL: state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State register, frozen while enable is low
  always_ff @(posedge clk or posedge arst) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    if (arst)        state_q <= IDLE;
    else if (enable) state_q <= state_d;
  end

  // Datapath: operand capture, iteration, result write-back
  always_ff @(posedge clk or posedge arst) begin
    // NOTE: datapath registers are plain flops here (no memory array), so all are cleared on reset.
    if (arst) begin
      cnt_q   <= '0;
      f3_q    <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      div0_q  <= 1'b0;
      result  <= '0;
    end else if (enable) begin
      unique case (state_q)
        IDLE: if (accept) begin
          f3_q    <= funct3;
          cnt_q   <= CNT_W'(DATA_W);
          neg_q_q <= a_neg ^ b_neg;
          neg_r_q <= a_neg;
          div0_q  <= b_zero;
          if (special_in) begin
            acc_q <= {{DATA_W{1'b0}}, op_a};
          end else if (funct3[2]) begin
            acc_q  <= {{DATA_W{1'b0}}, a_mag};
            opnd_q <= b_mag;
          end else begin
            acc_q  <= {{DATA_W{1'b0}}, b_mag};
            opnd_q <= a_mag;
          end
        end
        CALC: begin
          cnt_q <= cnt_q - CNT_W'(1);
          acc_q <= f3_q[2] ? div_next : {mul_sum, acc_q[DATA_W-1:1]};
        end
        FIX:     if (!kill) result <= fix_val;
        SPECIAL: if (!kill) result <= spec_val;
        default: ;
      endcase
    end
  end

  assign busy = (state_q == CALC) || (state_q == FIX) || (state_q == SPECIAL);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver queues expected results, monitor checks on done.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W    = 64;
  localparam int LAT  = W + 2;
  localparam int LATS = 2;

  logic         clk = 1'b0;
  logic         arst = 1'b1;
  logic         enable = 1'b1;
  logic         start = 1'b0;
  logic         kill = 1'b0;
  logic [2:0]   funct3 = '0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         busy, done;
  logic [W-1:0] result;

  muldiv_unit #(.DATA_W(W)) dut (
    .clk    (clk),
    .arst   (arst),
    .enable (enable),
    .start  (start),
    .kill   (kill),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [W-1:0] last_res = '0;

  typedef struct {
    logic [W-1:0] res;
    int           due;
    string        name;
  } exp_t;
  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (!arst && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want done=0 at cycle %0d", cyc);
      end else begin
        e = exp_q.pop_front();
        check(e.name, result, e.res);
        check({e.name, "_cycle"}, W'(cyc), W'(e.due));
      end
    end
  end

  // Issue one operation, optionally stall it or poke start while busy
  task automatic run_op(input string name, input logic [2:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] want, input int lat,
                        input int stall, input bit poke);
    int busy_cnt;
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    exp_q.push_back('{want, cyc + lat + stall, name});
    @(negedge clk);
    start = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0) break;
      if (busy) busy_cnt++;
      if (stall > 0 && i == 20) enable = 1'b0;
      if (stall > 0 && i == 20 + stall) enable = 1'b1;
      if (poke && i == 30) begin
        start = 1'b1; funct3 = MD_MULHU; op_a = '1; op_b = '1;
      end
      if (poke && i == 31) start = 1'b0;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done want done within 400 cycles", name);
      exp_q.delete();
    end
    check({name, "_busy_cycles"}, W'(busy_cnt), W'(lat - 1 + stall));
    last_res = want;
  endtask

  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ONES = '1;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_busy", W'(busy), '0);
    check("reset_done", W'(done), '0);
    check("reset_result", result, '0);
    arst = 1'b0;
    @(negedge clk);
    check("idle_busy", W'(busy), '0);

    run_op("mul_7x-3",      MD_MUL,    64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, LAT, 0, 0);
    run_op("mulhu_max_x2",  MD_MULHU,  ONES, 64'd2, 64'd1, LAT, 0, 0);
    run_op("mulh_m1_m1",    MD_MULH,   ONES, ONES, 64'd0, LAT, 0, 0);
    run_op("mulhsu_m1_2",   MD_MULHSU, ONES, 64'd2, ONES, LAT, 0, 0);
    run_op("mulh_min_min",  MD_MULH,   MIN, MIN, 64'h4000_0000_0000_0000, LAT, 0, 0);
    run_op("div_-7_2",      MD_DIV,    -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, LAT, 0, 0);
    run_op("rem_-7_2",      MD_REM,    -64'sd7, 64'd2, ONES, LAT, 0, 0);
    run_op("divu_100_7",    MD_DIVU,   64'd100, 64'd7, 64'd14, LAT, 0, 1);
    run_op("remu_100_7",    MD_REMU,   64'd100, 64'd7, 64'd2, LAT, 0, 0);
    run_op("divu_min_m1",   MD_DIVU,   MIN, ONES, 64'd0, LAT, 0, 0);
    run_op("div_5_0",       MD_DIV,    64'd5, 64'd0, ONES, LATS, 0, 0);
    run_op("rem_5_0",       MD_REM,    64'd5, 64'd0, 64'd5, LATS, 0, 0);
    run_op("remu_5_0",      MD_REMU,   64'd5, 64'd0, 64'd5, LATS, 0, 0);
    run_op("div_min_m1",    MD_DIV,    MIN, ONES, MIN, LATS, 0, 0);
    run_op("rem_min_m1",    MD_REM,    MIN, ONES, 64'd0, LATS, 0, 0);
    run_op("divu_stall5",   MD_DIVU,   64'd100, 64'd7, 64'd14, LAT, 5, 0);

    // Kill in the 10th CALC cycle: no done, result keeps its prior value
    @(negedge clk);
    funct3 = MD_MUL; op_a = 64'd3; op_b = 64'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy", W'(busy), '0);
    check("kill_result_held", result, last_res);
    repeat (80) @(negedge clk);
    check("kill_result_later", result, last_res);
    run_op("mul_after_kill", MD_MUL, 64'd3, 64'd5, 64'd15, LAT, 0, 0);

    // Asynchronous reset mid-CALC clears outputs immediately, no done afterwards
    @(negedge clk);
    funct3 = MD_DIV; op_a = 64'd1000; op_b = 64'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 arst = 1'b1;
    #1;
    check("arst_busy", W'(busy), '0);
    check("arst_done", W'(done), '0);
    check("arst_result", result, '0);
    @(negedge clk);
    arst = 1'b0;
    repeat (80) @(negedge clk);
    check("arst_no_restart", W'(busy), '0);
    run_op("remu_after_arst", MD_REMU, 64'd100, 64'd7, 64'd2, LAT, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV64M multiply/divide unit for the EXE stage of the 5-stage pipeline; successor to the single-cycle ALU path.
- Operand width is parametrised.
- Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles.
- Drives a busy signal that the hazard unit uses to freeze PC, IF/ID and ID/EXE, and supports pipeline kill (branch/jump flush).

Parameters:
- DATA_W, 64, operand/result width (even, >= 8).
- CNT_W, $clog2(DATA_W)+1, iteration counter width.

Ports:
- clk  in  1  main clock
- arst  in  1  asynchronous reset, active-high
- enable  in  1  global run enable; low freezes all state
- start  in  1  request; sampled only in IDLE with enable=1
- kill  in  1  abort current operation (flush)
- funct3  in  3  RV M-extension funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  in  DATA_W  rs1 value
- op_b  in  DATA_W  rs2 value
- busy  out  1  operation in progress; stall request to hazard unit
- done  out  1  one-cycle pulse, result valid
- result  out  DATA_W  result, held stable until the next accepted start

Behaviour:
- Reset (arst=1, asynchronous): state=IDLE, busy=0, done=0, result=0, counter=0, internal registers cleared. Reset mid-operation discards the operation; no done is produced.
- States:
  - IDLE: busy=0. On start&enable&~kill: latch funct3, convert operands to magnitudes (signedness per funct3), record result sign, then go to CALC. If it is a divide and op_b==0, or signed overflow (op_a=MIN, op_b=-1), go to SPECIAL instead.
  - CALC: busy=1; one radix-2 step per enabled cycle, counter counts DATA_W..1. Multiply: shift-add into a 2*DATA_W product. Divide: restoring shift-subtract giving quotient and remainder. At counter==1, go to FIX.
  - FIX: busy=1; apply sign correction; select result (low or high product half, quotient, or remainder); go to DONE.
  - SPECIAL: busy=1; select the fixed result; go to DONE.
  - DONE: busy=0, done=1 for exactly one cycle, result valid; return to IDLE. A start in the DONE cycle is ignored; the pipeline restarts from IDLE.
- Latency, counted in enabled cycles after the start edge:
  - normal op: done asserted DATA_W+2 cycles later (DATA_W in CALC, 1 in FIX, 1 in DONE);
  - special case: done asserted 2 cycles later.
- Arithmetic rules:
  - MULH signed×signed, MULHSU signed rs1 × unsigned rs2, MULHU unsigned; MUL returns the low DATA_W bits.
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = op_a.
  - Signed overflow (MIN / -1): DIV = MIN, REM = 0.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a). Division truncates toward zero.
- enable=0: state, counter and datapath registers hold; done, if currently high, stays high until enable returns.
- kill=1 in any state other than IDLE: next state IDLE, busy=0 and done=0 next cycle, result unchanged. kill together with start in IDLE: kill wins, request dropped.
- start while busy: ignored; no queueing.
- result and done are registered outputs; no combinational path from any input to any output.

Decomposition:
- Shared package: muldiv_pkg holds the funct3 localparams (MD_MUL..MD_REMU) and the state enum (IDLE, CALC, FIX, SPECIAL, DONE).
- Sub-module: muldiv_sign_fix (combinational magnitude/sign conversion and final negation), instantiated once on input and once on output.
- FSM and shift datapath stay in muldiv_unit.

Test Plan:
- MUL 7×(-3), DATA_W=64 -> done exactly 66 cycles after start; result=0xFFFF_FFFF_FFFF_FFEB; busy high during cycles 1..65.
- MULHU 0xFFFF_FFFF_FFFF_FFFF × 2 -> result=1. MULH (-1)×(-1) -> result=0. MULHSU (-1)×2 -> result=0xFFFF_FFFF_FFFF_FFFF.
- DIV -7/2 -> result=-3; REM -7/2 -> result=-1; DIVU 100/7 -> result=14; REMU 100/7 -> result=2.
- DIV 5/0 -> all ones after 2 cycles; REM 5/0 -> 5; DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; REM of the same operands -> 0.
- kill in CALC cycle 10 -> busy=0 next cycle, no done, result keeps prior value. A subsequent start completes normally.
- enable low for 5 cycles mid-CALC -> done delayed by exactly 5 cycles, same result. arst mid-CALC -> all outputs 0 immediately, no done after release.
